// File: rtl/l2_cache_nway.sv
// Write-back, write-allocate, N-way set-associative L2 cache with tree pseudo-LRU replacement.
// Define L2_NWAY_PERF_CNT_EN to add saturating hit/miss/writeback counters with a clear input.
module l2_cache_nway #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 8,
  localparam int s_tag    = 32 - s_offset - s_index,
  localparam int s_line   = 8 * 2**s_offset,
  localparam int s_mask   = 2**s_offset,
  localparam int s_way    = $clog2(num_ways),
  localparam int num_sets = 2**s_index
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata,
  input  logic [s_mask-1:0] mem_byte_enable,
  output logic [s_line-1:0] mem_rdata,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
`ifdef L2_NWAY_PERF_CNT_EN
  ,
  input  logic              perf_clear,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses,
  output logic [31:0]       perf_writebacks
`endif
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

  state_t                    state_q;
  logic [31-s_offset:0]      line_addr_q;
  logic [s_line-1:0]         wdata_q;
  logic [s_mask-1:0]         be_q;
  logic                      write_q;
  logic                      replay_q;
  logic [s_way-1:0]          victim_q;

  logic [s_tag-1:0]          tag_q   [num_ways][num_sets];
  logic [s_line-1:0]         data_q  [num_ways][num_sets];
  logic [num_ways-1:0]       valid_q [num_sets];
  logic [num_ways-1:0]       dirty_q [num_sets];
  logic [num_ways-2:0]       plru_q  [num_sets];

  logic [s_index-1:0]        idx;
  logic [s_tag-1:0]          req_tag;
  logic                      hit;
  logic [s_way-1:0]          hit_way;
  logic [s_way-1:0]          victim;
  logic [num_ways-2:0]       plru_next;
  logic [s_line-1:0]         merged;
  logic                      unused_offset;

  assign idx           = line_addr_q[s_index-1:0];
  assign req_tag       = line_addr_q[31-s_offset -: s_tag];
  assign unused_offset = ^mem_address[s_offset-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (!hit && valid_q[idx][w] && tag_q[w][idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = s_way'(w);
      end
    end
  end

  // Lowest invalid way wins; otherwise walk the tree toward the pointed-at half.
  always_comb begin : find_victim
    int node;
    node = 0;
    for (int l = 0; l < s_way; l++)
      node = 2 * node + 1 + int'(plru_q[idx][node]);
    victim = s_way'(node - (num_ways - 1));
    for (int w = num_ways - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = s_way'(w);
  end

  always_comb begin : touch_path
    int node;
    node      = 0;
    plru_next = plru_q[idx];
    for (int l = 0; l < s_way; l++) begin
      plru_next[node] = ~hit_way[s_way-1-l];
      node            = 2 * node + 1 + int'(hit_way[s_way-1-l]);
    end
  end

  always_comb begin
    merged = data_q[hit_way][idx];
    for (int i = 0; i < s_mask; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (state_q == FILL && pmem_resp) begin
      data_q[victim_q][idx] <= pmem_rdata;
      tag_q[victim_q][idx]  <= req_tag;
    end else if (state_q == CHECK && hit && write_q) begin
      data_q[hit_way][idx] <= merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      line_addr_q  <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      write_q      <= 1'b0;
      replay_q     <= 1'b0;
      victim_q     <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      mem_resp <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The held request is ignored during its own response cycle.
          if ((mem_read || mem_write) && !mem_resp) begin
            line_addr_q <= mem_address[31:s_offset];
            wdata_q     <= mem_wdata;
            be_q        <= mem_byte_enable;
            write_q     <= mem_write;
            replay_q    <= 1'b0;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            mem_resp    <= 1'b1;
            mem_rdata   <= data_q[hit_way][idx];
            plru_q[idx] <= plru_next;
            if (write_q) dirty_q[idx][hit_way] <= 1'b1;
            state_q     <= IDLE;
          end else begin
            victim_q <= victim;
            if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
              pmem_write   <= 1'b1;
              pmem_address <= {tag_q[victim][idx], idx, {s_offset{1'b0}}};
              pmem_wdata   <= data_q[victim][idx];
              state_q      <= WRITEBACK;
            end else begin
              pmem_read    <= 1'b1;
              pmem_address <= {req_tag, idx, {s_offset{1'b0}}};
              state_q      <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_address <= {req_tag, idx, {s_offset{1'b0}}};
            state_q      <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            pmem_read                <= 1'b0;
            valid_q[idx][victim_q]   <= 1'b1;
            dirty_q[idx][victim_q]   <= 1'b0;
            replay_q                 <= 1'b1;
            state_q                  <= CHECK;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef L2_NWAY_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else if (perf_clear) begin
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      if (state_q == CHECK && hit && !replay_q && perf_hits != '1)
        perf_hits <= perf_hits + 32'd1;
      if (state_q == CHECK && !hit && perf_misses != '1)
        perf_misses <= perf_misses + 32'd1;
      if (state_q == WRITEBACK && pmem_resp && perf_writebacks != '1)
        perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif

  always @(posedge clk) begin
    if (!rst && state_q == IDLE && !mem_resp)
      assert (!(mem_read && mem_write))
        else $warning("l2_cache_nway: read and write requested together, handled as write");
  end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed plus randomized bench for l2_cache_nway against a set/way/tree-PLRU reference model.
module tb_l2_cache_nway;
  localparam int SO = 5, SI = 3, NW = 8, NS = 8;
  localparam int TW = 32 - SO - SI, LW = 256, BW = 32;

  logic          clk = 1'b0, rst = 1'b0;
  logic          mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0]   mem_address = '0;
  logic [LW-1:0] mem_wdata = '0;
  logic [BW-1:0] mem_byte_enable = '0;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          pmem_read, pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
`ifdef L2_NWAY_PERF_CNT_EN
  logic          perf_clear = 1'b0;
  logic [31:0]   perf_hits, perf_misses, perf_writebacks;
`endif

  always #5 clk = ~clk;

  l2_cache_nway #(.s_offset(SO), .s_index(SI), .num_ways(NW)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef L2_NWAY_PERF_CNT_EN
    , .perf_clear(perf_clear), .perf_hits(perf_hits), .perf_misses(perf_misses),
    .perf_writebacks(perf_writebacks)
`endif
  );

  int vectors = 0, fails = 0;

  // Reference model: physical memory plus per-set way contents and tree bits.
  logic [LW-1:0] mem_model [logic [31:0]];
  bit            m_valid [NS][NW];
  bit            m_dirty [NS][NW];
  logic [TW-1:0] m_tag   [NS][NW];
  logic [LW-1:0] m_data  [NS][NW];
  bit            m_plru  [NS][NW-1];
  int            m_hits, m_misses, m_wbs;

  bit            exp_hit;
  int            exp_n;
  bit            exp_w [2];
  logic [31:0]   exp_a [2];
  logic [LW-1:0] exp_d [2];
  logic [LW-1:0] exp_rd;

  logic [LW-1:0] last_rdata;
  int            last_ntx;
  bit            last_tx_w [4];
  logic [31:0]   last_tx_a [4];

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_get(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = rand_line();
    return mem_model[a];
  endfunction

  function automatic int plru_victim(input int s);
    int lo = 0, hi = NW, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_plru[s][node]) begin lo = mid; node = 2 * node + 2; end
      else begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  function automatic void plru_touch(input int s, input int w);
    int lo = 0, hi = NW, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin m_plru[s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
      else begin m_plru[s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
    end
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; end
      for (int n = 0; n < NW - 1; n++) m_plru[s][n] = 1'b0;
    end
    m_hits = 0; m_misses = 0; m_wbs = 0;
  endfunction

  task automatic model_access(input bit wr, input logic [31:0] addr,
                              input logic [LW-1:0] wd, input logic [BW-1:0] be);
    int s, w;
    logic [TW-1:0] t;
    s = int'(addr[SO +: SI]);
    t = addr[31 -: TW];
    w = -1;
    exp_n = 0;
    for (int i = 0; i < NW; i++) if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
    exp_hit = (w >= 0);
    if (w < 0) begin
      m_misses++;
      for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = plru_victim(s);
      if (m_valid[s][w] && m_dirty[s][w]) begin
        exp_w[0] = 1'b1;
        exp_a[0] = {m_tag[s][w], addr[SO +: SI], {SO{1'b0}}};
        exp_d[0] = m_data[s][w];
        exp_n    = 1;
        m_wbs++;
      end
      exp_w[exp_n] = 1'b0;
      exp_a[exp_n] = {t, addr[SO +: SI], {SO{1'b0}}};
      exp_d[exp_n] = '0;
      exp_n++;
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
      m_data[s][w]  = mem_get(exp_a[exp_n-1]);
    end else begin
      m_hits++;
    end
    exp_rd = m_data[s][w];
    if (wr) begin
      for (int b = 0; b < BW; b++) if (be[b]) m_data[s][w][8*b +: 8] = wd[8*b +: 8];
      m_dirty[s][w] = 1'b1;
    end
    plru_touch(s, w);
  endtask

  // One upstream request; the loop also plays physical memory with a fixed response delay.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                        input logic [BW-1:0] be, input int lat);
    int c, n_tx, cnt, exp_lat;
    bit got, active, overlap;
    bit            tx_w [4];
    logic [31:0]   tx_a [4];
    logic [LW-1:0] tx_d [4];
    model_access(wr, addr, wd, be);
    exp_lat = exp_hit ? 2 : 2 + exp_n * (lat + 1) + 1;
    vectors++;
    @(negedge clk);
    mem_read = !wr; mem_write = wr; mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
    c = 0; n_tx = 0; cnt = 0; got = 0; active = 0; overlap = 0;
    while (!got && c < 200) begin
      @(negedge clk);
      c++;
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap = 1;
      if (mem_resp) begin
        got = 1;
        last_rdata = mem_rdata;
        if (pmem_read || pmem_write) overlap = 1;
      end else if (pmem_read || pmem_write) begin
        if (!active) begin
          active = 1;
          cnt = lat;
          if (n_tx < 4) begin tx_w[n_tx] = pmem_write; tx_a[n_tx] = pmem_address; tx_d[n_tx] = pmem_wdata; end
          n_tx++;
        end else cnt--;
        if (cnt <= 0) begin
          pmem_resp = 1'b1;
          active = 0;
          if (pmem_write) mem_model[pmem_address] = pmem_wdata;
          else pmem_rdata = mem_get(pmem_address);
        end
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    last_ntx = n_tx;
    for (int i = 0; i < 4; i++) begin last_tx_w[i] = tx_w[i]; last_tx_a[i] = tx_a[i]; end
    check("resp_seen", LW'(got), LW'(1));
    if (got) check("latency", LW'(c), LW'(exp_lat));
    check("pmem_tx_count", LW'(n_tx), LW'(exp_n));
    for (int i = 0; i < exp_n && i < n_tx; i++) begin
      check("pmem_tx_kind", LW'(tx_w[i]), LW'(exp_w[i]));
      check("pmem_tx_addr", LW'(tx_a[i]), LW'(exp_a[i]));
      if (exp_w[i]) check("pmem_wb_data", tx_d[i], exp_d[i]);
    end
    if (!wr && got) check("rdata", last_rdata, exp_rd);
    check("no_overlap", LW'(overlap), LW'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    check("rst_mem_resp", LW'(mem_resp), LW'(0));
    check("rst_pmem_read", LW'(pmem_read), LW'(0));
    check("rst_pmem_write", LW'(pmem_write), LW'(0));
    check("rst_mem_rdata", mem_rdata, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] mk_addr(input int tag, input int set, input int off);
    logic [31:0] a;
    a = (32'(tag) << (SO + SI)) | (32'(set) << SO) | 32'(off);
    return a;
  endfunction

  initial begin : main
    logic [LW-1:0] line_a, wd;
    int c;
    model_reset();
    do_reset();

    // Cold read, then immediate re-read.
    do_req(1'b0, 32'h0000_1040, '0, '0, 3);
    line_a = mem_model[32'h0000_1040];
    check("cold_rdata_a", last_rdata, line_a);
    do_req(1'b0, 32'h0000_1040, '0, '0, 3);

    // Partial write of the low word, then read back.
    wd = rand_line();
    wd[31:0] = 32'hDEAD_BEEF;
    do_req(1'b1, 32'h0000_1040, wd, 32'h0000_000F, 2);
    do_req(1'b0, 32'h0000_1040, '0, '0, 2);
    begin : wr_words
      logic [31:0] lo_word;
      logic [LW-33:0] hi_part, hi_exp;
      lo_word = last_rdata[31:0];
      hi_part = last_rdata[LW-1:32];
      hi_exp  = line_a[LW-1:32];
      check("write_low_word", LW'(lo_word), LW'(32'hDEAD_BEEF));
      check("write_upper_kept", LW'(hi_part), LW'(hi_exp));
    end

    // Reset while a fill is outstanding; a late pmem_resp must be ignored.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h0000_2040;
    c = 0;
    while (!pmem_read && c < 20) begin @(negedge clk); c++; end
    check("fill_reached", LW'(pmem_read), LW'(1));
    rst = 1'b1;
    #1;
    vectors++;
    check("rst_drops_pmem_read", LW'(pmem_read), LW'(0));
    check("rst_mem_resp_low", LW'(mem_resp), LW'(0));
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pmem_rdata = rand_line();
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_resp_no_mem_resp", LW'(mem_resp), LW'(0));
      check("late_resp_idle", LW'(pmem_read | pmem_write), LW'(0));
      @(negedge clk);
    end
    model_reset();
    do_req(1'b0, 32'h0000_1040, '0, '0, 1);
    check("post_rst_miss", LW'(last_ntx), LW'(1));

    // Fill set 2 with tags 0..7, touch 0..6 so that the tree points at way 7.
    do_reset();
    for (int t = 0; t < 8; t++) do_req(1'b0, mk_addr(t, 2, 0), '0, '0, 1);
    foreach (exp_w[i]) exp_w[i] = 1'b0;
    begin : touch_seq
      int order [7] = '{6, 4, 5, 0, 1, 2, 3};
      for (int i = 0; i < 7; i++) do_req(1'b0, mk_addr(order[i], 2, 4), '0, '0, 1);
    end
    do_req(1'b0, mk_addr(8, 2, 0), '0, '0, 2);
    check("evict_clean_ntx", LW'(last_ntx), LW'(1));
    for (int t = 0; t < 7; t++) do_req(1'b0, mk_addr(t, 2, 0), '0, '0, 1);
    do_req(1'b0, mk_addr(7, 2, 0), '0, '0, 1);
    check("way7_was_evicted", LW'(last_ntx), LW'(1));

    // Dirty victim: fill set 5 with written lines, then force an eviction.
    for (int t = 0; t < 8; t++) do_req(1'b1, mk_addr(t, 5, 0), rand_line(), 32'(~0) ^ 32'(t), 1);
    do_req(1'b0, mk_addr(8, 5, 0), '0, '0, 2);
    check("dirty_ntx", LW'(last_ntx), LW'(2));
    check("dirty_first_is_write", LW'(last_tx_w[0]), LW'(1));
    check("dirty_then_read", LW'(last_tx_w[1]), LW'(0));
    check("dirty_wb_addr", LW'(last_tx_a[0]), LW'(mk_addr(0, 5, 0)));
    check("dirty_fill_addr", LW'(last_tx_a[1]), LW'(mk_addr(8, 5, 0)));

    // Random traffic over a small tag pool to force conflicts and dirty evictions.
    for (int n = 0; n < 250; n++) begin
      do_req(1'($urandom_range(0, 1)),
             mk_addr($urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 31)),
             rand_line(), $urandom, $urandom_range(1, 4));
    end

`ifdef L2_NWAY_PERF_CNT_EN
    check("perf_hits", LW'(perf_hits), LW'(m_hits));
    check("perf_misses", LW'(perf_misses), LW'(m_misses));
    check("perf_writebacks", LW'(perf_writebacks), LW'(m_wbs));
    @(negedge clk);
    perf_clear = 1'b1;
    @(negedge clk);
    perf_clear = 1'b0;
    check("perf_clear", LW'(perf_hits | perf_misses | perf_writebacks), LW'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
